// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// memory-ready stalls, flag-based branch resolution and stack depth tracking.
// Ports: clock/reset (sync, active-high); opcode, instr_valid, mem_ready,
// zero_flag, neg_flag in; datapath strobes/selects, stack_depth,
// stack_fault, illegal_op out.
module multicycle_control_unit #(
    parameter int OPCODE_W    = 6,
    parameter int STACK_DEPTH = 16,
    parameter int DEPTH_W     = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_valid,
    input  logic                mem_ready,
    input  logic                zero_flag,
    input  logic                neg_flag,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_control,
    output logic                regWr,
    output logic [1:0]          AluOp,
    output logic                AluSrc,
    output logic                Ext,
    output logic                Wresult,
    output logic                Bw2,
    output logic                MemRd,
    output logic                MemWr,
    output logic                DMadd,
    output logic                DMdata,
    output logic                SP,
    output logic                sp_en,
    output logic [DEPTH_W-1:0]  stack_depth,
    output logic                stack_fault,
    output logic                illegal_op
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
    } state_t;

    typedef logic [OPCODE_W-1:0] op_t;
    localparam op_t OP_AND = op_t'(0);
    localparam op_t OP_ADD = op_t'(1);
    localparam op_t OP_SUB = op_t'(2);
    localparam op_t OP_ANDI = op_t'(3);
    localparam op_t OP_ADDI = op_t'(4);
    localparam op_t OP_LW = op_t'(5);
    localparam op_t OP_LWP = op_t'(6);
    localparam op_t OP_SW = op_t'(7);
    localparam op_t OP_BGT = op_t'(8);
    localparam op_t OP_BLT = op_t'(9);
    localparam op_t OP_BEQ = op_t'(10);
    localparam op_t OP_BNE = op_t'(11);
    localparam op_t OP_JMP = op_t'(12);
    localparam op_t OP_CALL = op_t'(13);
    localparam op_t OP_RET = op_t'(14);
    localparam op_t OP_PUSH = op_t'(15);
    localparam op_t OP_POP = op_t'(16);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    state_t               state_q, state_d;
    op_t                  opcode_q, opcode_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 fault_q, fault_d;

    logic is_illegal, is_branch, is_push, is_pop, is_stack;
    logic is_read, is_write, is_ldst, taken, in_instr;

    always_comb begin
        is_illegal = opcode_q > OP_POP;
        is_branch  = opcode_q inside {OP_BGT, OP_BLT, OP_BEQ, OP_BNE};
        is_push    = opcode_q inside {OP_CALL, OP_PUSH};
        is_pop     = opcode_q inside {OP_RET, OP_POP};
        is_stack   = is_push || is_pop;
        is_read    = opcode_q inside {OP_LW, OP_LWP, OP_RET, OP_POP};
        is_write   = opcode_q inside {OP_SW, OP_CALL, OP_PUSH};
        is_ldst    = opcode_q inside {OP_LW, OP_LWP, OP_SW};
        taken      = 1'b0;
        unique case (opcode_q)
            OP_BEQ:  taken = zero_flag;
            OP_BNE:  taken = !zero_flag;
            OP_BGT:  taken = !zero_flag && !neg_flag;
            OP_BLT:  taken = neg_flag;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        depth_d     = depth_q;
        fault_d     = fault_q;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_control  = 2'd0;
        regWr       = 1'b0;
        AluOp       = 2'd0;
        AluSrc      = 1'b0;
        Ext         = 1'b0;
        Wresult     = 1'b0;
        Bw2         = 1'b0;
        MemRd       = 1'b0;
        MemWr       = 1'b0;
        DMadd       = 1'b0;
        DMdata      = 1'b0;
        SP          = 1'b0;
        sp_en       = 1'b0;
        illegal_op  = 1'b0;
        in_instr    = state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB};

        // Selects are decoded from the latched opcode for the whole
        // instruction; reset forces everything low in the same cycle.
        if (!reset && in_instr && !is_illegal) begin
            if (opcode_q inside {OP_AND, OP_ANDI})
                AluOp = 2'd2;
            else if (opcode_q == OP_SUB || is_branch)
                AluOp = 2'd1;
            AluSrc  = opcode_q inside {OP_ANDI, OP_ADDI} || is_ldst || is_branch;
            Ext     = opcode_q inside {OP_ANDI, OP_ADDI};
            Wresult = opcode_q inside {OP_LW, OP_LWP, OP_POP};
            Bw2     = opcode_q == OP_LWP;
            DMadd   = is_stack;
            DMdata  = opcode_q == OP_CALL;
            SP      = is_pop;
            if (opcode_q inside {OP_JMP, OP_CALL})
                pc_control = 2'd2;
            else if (opcode_q == OP_RET)
                pc_control = 2'd3;
            else if (is_branch && taken)
                pc_control = 2'd1;
        end

        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir_write = 1'b1;
                        opcode_d = opcode;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_illegal) begin
                        illegal_op = 1'b1;
                        pc_write   = 1'b1;
                        state_d    = S_FETCH;
                    end else if (opcode_q == OP_JMP) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else if ((is_push && depth_q == DEPTH_MAX) ||
                                 (is_pop && depth_q == '0)) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else if (is_stack) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_branch) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else if (is_ldst) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    MemRd = is_read;
                    MemWr = is_write;
                    if (mem_ready) begin
                        if (is_stack) begin
                            sp_en   = 1'b1;
                            depth_d = is_push ? depth_q + DEPTH_ONE
                                              : depth_q - DEPTH_ONE;
                        end
                        if (is_write || opcode_q == OP_RET) begin
                            pc_write = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    regWr    = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            depth_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            depth_q  <= depth_d;
            fault_q  <= fault_d;
        end
    end

    assign stack_depth = depth_q;
    assign stack_fault = fault_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit.
// Inputs change 1 time unit after the rising edge; outputs checked 1 later.
module tb_multicycle_control_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       instr_valid, mem_ready, zero_flag, neg_flag;
    logic       ir_write, pc_write, regWr, AluSrc, Ext, Wresult, Bw2;
    logic       MemRd, MemWr, DMadd, DMdata, SP, sp_en;
    logic       stack_fault, illegal_op;
    logic [1:0] pc_control, AluOp;
    logic [4:0] stack_depth;

    int checks = 0;
    int failures = 0;

    multicycle_control_unit #(
        .OPCODE_W(6), .STACK_DEPTH(16), .DEPTH_W(5)
    ) dut (
        .clock(clock), .reset(reset), .opcode(opcode),
        .instr_valid(instr_valid), .mem_ready(mem_ready),
        .zero_flag(zero_flag), .neg_flag(neg_flag),
        .ir_write(ir_write), .pc_write(pc_write),
        .pc_control(pc_control), .regWr(regWr), .AluOp(AluOp),
        .AluSrc(AluSrc), .Ext(Ext), .Wresult(Wresult), .Bw2(Bw2),
        .MemRd(MemRd), .MemWr(MemWr), .DMadd(DMadd), .DMdata(DMdata),
        .SP(SP), .sp_en(sp_en), .stack_depth(stack_depth),
        .stack_fault(stack_fault), .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // FETCH cycle: present opcode, expect ir_write, leave in DECODE
    task automatic fetch(input int op);
        opcode = 6'(op);
        instr_valid = 1'b1;
        #1 chk("fetch_irw", int'(ir_write), 1);
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int mem_cycles;
    int total;

    initial begin
        reset = 1'b1; opcode = '0; instr_valid = 1'b0;
        mem_ready = 1'b0; zero_flag = 1'b0; neg_flag = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_irw", int'(ir_write), 0);
        chk("rst_pcw", int'(pc_write), 0);
        chk("rst_aluop", int'(AluOp), 0);
        chk("rst_depth", int'(stack_depth), 0);
        chk("rst_fault", int'(stack_fault), 0);
        tick();

        // ADD with instr_valid held high
        opcode = 6'd1; instr_valid = 1'b1;
        #1 chk("add_c0_irw", int'(ir_write), 1);
        tick();
        #1 chk("add_c1_regwr", int'(regWr), 0);
        tick();
        #1 chk("add_c2_aluop", int'(AluOp), 0);
        chk("add_c2_alusrc", int'(AluSrc), 0);
        tick();
        #1 chk("add_c3_regwr", int'(regWr), 1);
        chk("add_c3_wres", int'(Wresult), 0);
        chk("add_c3_pcw", int'(pc_write), 1);
        chk("add_c3_pcc", int'(pc_control), 0);
        tick();
        #1 chk("add_c4_irw", int'(ir_write), 1);
        instr_valid = 1'b0;
        #1 chk("idle_irw", int'(ir_write), 0);

        // LW_POI with two wait cycles
        fetch(6); total = 1;
        tick(); total++;
        #1 chk("lwp_ext", int'(Ext), 0);
        chk("lwp_alusrc", int'(AluSrc), 1);
        tick(); total++;
        mem_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #1 if (MemRd) mem_cycles++;
            tick(); total++;
        end
        mem_ready = 1'b0;
        chk("lwp_memrd_cycles", mem_cycles, 3);
        #1 chk("lwp_wb_regwr", int'(regWr), 1);
        chk("lwp_wb_wres", int'(Wresult), 1);
        chk("lwp_wb_bw2", int'(Bw2), 1);
        tick(); total++;
        chk("lwp_total", total, 7);
        #1 chk("lwp_back_fetch_memrd", int'(MemRd), 0);

        // ANDI: and op, unsigned extend
        fetch(3); tick();
        #1 chk("andi_aluop", int'(AluOp), 2);
        chk("andi_ext", int'(Ext), 1);
        tick(); tick();

        // Branches: BEQ z=1 taken, BLT n=0 not, BGT z=0 n=0 taken, BNE z=1 not
        fetch(10); tick();
        zero_flag = 1'b1; neg_flag = 1'b0;
        #1 chk("beq_pcw", int'(pc_write), 1);
        chk("beq_pcc", int'(pc_control), 1);
        chk("beq_aluop", int'(AluOp), 1);
        tick();
        fetch(9); tick();
        zero_flag = 1'b0; neg_flag = 1'b0;
        #1 chk("blt_pcw", int'(pc_write), 1);
        chk("blt_pcc", int'(pc_control), 0);
        tick();
        fetch(8); tick();
        #1 chk("bgt_pcc", int'(pc_control), 1);
        tick();
        fetch(11); tick();
        zero_flag = 1'b1;
        #1 chk("bne_pcc", int'(pc_control), 0);
        tick();
        zero_flag = 1'b0;

        // JMP: two cycles, JA
        fetch(12);
        #1 chk("jmp_pcw", int'(pc_write), 1);
        chk("jmp_pcc", int'(pc_control), 2);
        tick();

        // Fill the stack with 16 PUSHes
        mem_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            fetch(15); tick();
            #1 if (i == 0) begin
                chk("push_memwr", int'(MemWr), 1);
                chk("push_dmadd", int'(DMadd), 1);
                chk("push_spen", int'(sp_en), 1);
                chk("push_sp", int'(SP), 0);
            end
            tick();
        end
        chk("push16_depth", int'(stack_depth), 16);
        fetch(15);
        #1 chk("push17_memwr", int'(MemWr), 0);
        tick();
        #1 chk("push17_fault", int'(stack_fault), 1);
        instr_valid = 1'b1;
        #1 chk("fault_irw", int'(ir_write), 0);
        tick(); tick();
        #1 chk("fault_sticky", int'(stack_fault), 1);
        chk("fault_memwr", int'(MemWr), 0);
        instr_valid = 1'b0;
        do_reset();
        #1 chk("after_rst_depth", int'(stack_depth), 0);
        chk("after_rst_fault", int'(stack_fault), 0);

        // CALL then RET
        fetch(13); tick();
        #1 chk("call_memwr", int'(MemWr), 1);
        chk("call_dmdata", int'(DMdata), 1);
        chk("call_dmadd", int'(DMadd), 1);
        chk("call_pcw", int'(pc_write), 1);
        chk("call_pcc", int'(pc_control), 2);
        tick();
        chk("call_depth", int'(stack_depth), 1);
        fetch(14); tick();
        #1 chk("ret_memrd", int'(MemRd), 1);
        chk("ret_sp", int'(SP), 1);
        chk("ret_pcc", int'(pc_control), 3);
        chk("ret_spen", int'(sp_en), 1);
        tick();
        chk("ret_depth", int'(stack_depth), 0);
        fetch(16); tick();
        #1 chk("pop0_fault", int'(stack_fault), 1);
        do_reset();

        // Illegal opcode 40
        fetch(40);
        #1 chk("ill_pulse", int'(illegal_op), 1);
        chk("ill_pcw", int'(pc_write), 1);
        chk("ill_pcc", int'(pc_control), 0);
        chk("ill_regwr", int'(regWr), 0);
        chk("ill_memwr", int'(MemWr), 0);
        tick();
        #1 chk("ill_pulse_end", int'(illegal_op), 0);

        // Reset during a stalled SW in MEM
        mem_ready = 1'b0;
        fetch(7); tick(); tick();
        #1 chk("sw_memwr", int'(MemWr), 1);
        tick();
        #1 chk("sw_stall_memwr", int'(MemWr), 1);
        reset = 1'b1;
        #1 chk("sw_rst_memwr", int'(MemWr), 0);
        chk("sw_rst_spen", int'(sp_en), 0);
        tick();
        reset = 1'b0;
        opcode = 6'd1; instr_valid = 1'b1;
        #1 chk("sw_rst_fetch", int'(ir_write), 1);
        chk("sw_rst_depth", int'(stack_depth), 0);
        instr_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-cycle processor control unit. It steps each instruction through a FETCH/DECODE/EXEC/MEM/WB state machine instead of decoding every cycle. It stalls on a memory-ready handshake, resolves branches from ALU flags and tracks stack depth with overflow/underflow faults. It sits between the instruction register, datapath muxes, ALU, data memory and PC logic.

Parameters:
OPCODE_W, 6, opcode width; opcodes above 16 are illegal.
STACK_DEPTH, 16, maximum number of entries on the CALL/PUSH stack.
DEPTH_W, 5, width of the stack_depth counter; must satisfy 2^DEPTH_W > STACK_DEPTH.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
opcode  in  OPCODE_W  opcode from instruction memory; captured on ir_write.
instr_valid  in  1  instruction memory data valid.
mem_ready  in  1  data memory access complete.
zero_flag  in  1  ALU zero result.
neg_flag  in  1  ALU negative result.
ir_write  out  1  load instruction register.
pc_write  out  1  update PC with the source selected by pc_control.
pc_control  out  2  0 next, 1 BTA, 2 JA, 3 top of stack.
regWr  out  1  register file write strobe.
AluOp  out  2  0 add, 1 sub, 2 and.
AluSrc  out  1  0 register, 1 immediate.
Ext  out  1  0 signed, 1 unsigned extend.
Wresult  out  1  0 ALU result, 1 memory data to the register file.
Bw2  out  1  second write bus: 0 rs, 1 rs+1.
MemRd  out  1  data memory read strobe.
MemWr  out  1  data memory write strobe.
DMadd  out  1  address: 0 ALU, 1 stack pointer.
DMdata  out  1  write data: 0 register Rd, 1 PC+1.
SP  out  1  stack pointer direction: 0 push, 1 pop.
sp_en  out  1  stack pointer update strobe.
stack_depth  out  DEPTH_W  current stack entries.
stack_fault  out  1  sticky overflow/underflow flag.
illegal_op  out  1  one-cycle pulse when DECODE sees an illegal opcode.

Behaviour:
- Opcode encoding: AND 0, ADD 1, SUB 2, ANDI 3, ADDI 4, LW 5, LW_POI 6, SW 7, BGT 8, BLT 9, BEQ 10, BNE 11, JMP 12, CALL 13, RET 14, PUSH 15, POP 16.
- Reset state is FETCH. All outputs are 0 at reset, with stack_depth 0 and the latched opcode 0.
- Strobes (ir_write, pc_write, regWr, MemRd, MemWr, sp_en, illegal_op) are combinational from the state and the latched opcode. They are asserted only in the states listed below.
- Mux selects hold their decoded value from DECODE through the end of the instruction.
- FETCH: wait for instr_valid. On instr_valid, pulse ir_write and go to DECODE.
- DECODE:
  - Illegal opcode: pulse illegal_op, pc_write with next, go to FETCH.
  - JMP: pc_write with JA, go to FETCH.
  - CALL/PUSH with stack_depth==STACK_DEPTH, or RET/POP with stack_depth==0: set stack_fault, go to FAULT.
  - CALL/RET/PUSH/POP otherwise: go to MEM.
  - All other opcodes: go to EXEC.
- EXEC:
  - ALU settings: AND/ANDI use AluOp=and; SUB and branches use sub; all others use add.
  - AluSrc=1 for immediate, load/store and branch opcodes. Ext=1 only for ANDI/ADDI.
  - R/I-type: go to WB. LW/LW_POI/SW: go to MEM.
  - Branch: sample flags this cycle. Taken conditions are BEQ zero, BNE !zero, BGT !zero&&!neg, BLT neg. Pulse pc_write with BTA if taken, else next. Go to FETCH.
- MEM: hold MemRd or MemWr until mem_ready, sampled each cycle; a zero-wait memory completes in one cycle.
  - Reads: LW, LW_POI, RET, POP. Writes: SW, CALL, PUSH.
  - DMadd=1 and DMdata=1 (CALL only) for stack ops.
  - On mem_ready with stack ops: pulse sp_en. SP=0 and depth+1 for CALL/PUSH; SP=1 and depth-1 for RET/POP.
  - Next state on mem_ready:
    - CALL: pc_write with JA, go to FETCH.
    - RET: pc_write with top of stack, go to FETCH.
    - POP/LW/LW_POI: go to WB.
    - SW/PUSH: pc_write with next, go to FETCH.
- WB: pulse regWr and pc_write with next, go to FETCH.
  - Wresult=1 for LW/LW_POI/POP.
  - Bw2=1 for LW_POI only; that instruction writes both Rd and rs+1 in the same cycle.
- FAULT: all strobes 0. Stays in FAULT until reset; stack_fault stays 1.
- Reset mid-MEM: strobes drop the same cycle reset is sampled high; no sp_en and no depth change.
- Latency with zero waits: ALU 4 cycles, LW 5, SW 4, branch 3, JMP 2, CALL/RET/PUSH 3, POP 4.
- Each cycle mem_ready or instr_valid stays low adds exactly 1 cycle.

Test Plan:
- Reset, then ADD with instr_valid=1 held -> ir_write in cycle 0, regWr=1 with Wresult=0 in cycle 3, pc_write=1 with pc_control=0, back in FETCH in cycle 4.
- LW_POI with mem_ready low for 2 cycles -> MemRd held 3 cycles, then one WB cycle with regWr=1, Wresult=1, Bw2=1. Total 7 cycles.
- BEQ with zero=1 -> pc_control=1 with pc_write in EXEC. BLT with neg=0 -> pc_control=0.
- 16 PUSHes -> stack_depth=16. 17th PUSH -> stack_fault=1, no MemWr, FSM stuck in FAULT until reset, which clears depth to 0.
- CALL then RET -> MemWr with DMdata=1 and DMadd=1, pc_control=2 and depth 1; then MemRd, pc_control=3 and depth 0. POP at depth 0 -> stack_fault=1.
- Opcode 40 -> illegal_op pulse in DECODE, pc_write with pc_control=0, no regWr/MemWr. Reset asserted during a stalled SW MEM -> MemWr=0 the same cycle, FETCH next.
